// File: rtl/gbe_rx_app_ctrl_if.sv
// GbE receive application controller
// Consumer-side byte stream with frame source address.
interface gbe_rx_app_ctrl_if;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic [31:0] out_srcip;
  logic [15:0] out_srcport;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    output out_srcip,
    output out_srcport,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    input  out_srcip,
    input  out_srcport,
    output out_ready
  );
endinterface

// File: rtl/gbe_rx_app_ctrl.sv
// GbE receive application controller
// Forwards, truncates or drops FIFO frames; recovers from overrun.
module gbe_rx_app_ctrl #(
  parameter logic [10:0] MAX_LEN    = 11'd1472,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic        app_clk,
  input  logic        app_rst_n,
  input  logic        enable,
  input  logic [7:0]  rx_data,
  input  logic        rx_dvld,
  input  logic        rx_eof,
  input  logic        rx_badframe,
  input  logic [31:0] rx_srcip,
  input  logic [15:0] rx_srcport,
  input  logic        rx_overrun,
  output logic        rx_ack,
  output logic        rx_rst,
  gbe_rx_app_ctrl_if.master out_if,
  output logic        frm_done,
  output logic [10:0] frm_len,
  output logic [1:0]  frm_err,
  input  logic        cnt_clr,
  output logic [31:0] frame_cnt,
  output logic [15:0] drop_cnt,
  output logic [15:0] ovr_cnt
);

  typedef enum logic [1:0] {
    IDLE, PASS, FLUSH, RECOVER
  } state_t;

  localparam logic [10:0] LAST_IDX = MAX_LEN - 11'd1;
  localparam logic [3:0]  RST_LOAD = 4'(RST_CYCLES - 1);

  state_t      state_q, state_d;
  logic [10:0] byte_cnt;
  logic        trunc_q;
  logic [3:0]  rst_cnt;
  logic [31:0] srcip_q;
  logic [15:0] srcport_q;
  logic        ack, vld, lst;
  logic        at_last, accept, frm_end;
  logic        ev_start, ev_drop, ev_rec;
  logic        ev_eof, ev_trunc, ev_fl_eof, ev_abort;

  assign at_last = (byte_cnt == LAST_IDX);
  assign accept  = ack && (state_q == PASS);
  assign frm_end = ev_eof || (ev_fl_eof && trunc_q);

  assign rx_ack              = ack;
  assign out_if.out_valid    = vld;
  assign out_if.out_last     = lst;
  assign out_if.out_data     = (state_q == PASS) ? rx_data : 8'd0;
  assign out_if.out_srcip    = srcip_q;
  assign out_if.out_srcport  = srcport_q;

  // State register
  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state, handshake outputs and frame events
  always_comb begin
    state_d   = state_q;
    ack       = 1'b0;
    vld       = 1'b0;
    lst       = 1'b0;
    ev_start  = 1'b0;
    ev_drop   = 1'b0;
    ev_rec    = 1'b0;
    ev_eof    = 1'b0;
    ev_trunc  = 1'b0;
    ev_fl_eof = 1'b0;
    ev_abort  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_overrun) begin
          state_d = RECOVER;
          ev_rec  = 1'b1;
        end else if (rx_dvld && enable) begin
          state_d  = PASS;
          ev_start = 1'b1;
        end else if (rx_dvld) begin
          state_d = FLUSH;
          ev_drop = 1'b1;
        end
      end
      PASS: begin
        if (rx_overrun) begin
          state_d  = RECOVER;
          ev_rec   = 1'b1;
          ev_abort = 1'b1;
        end else begin
          vld = rx_dvld;
          ack = rx_dvld && out_if.out_ready;
          lst = rx_dvld && (rx_eof || at_last);
          if (ack && rx_eof) begin
            state_d = IDLE;
            ev_eof  = 1'b1;
          end else if (ack && at_last) begin
            state_d  = FLUSH;
            ev_trunc = 1'b1;
          end
        end
      end
      FLUSH: begin
        if (rx_overrun) begin
          state_d = RECOVER;
          ev_rec  = 1'b1;
        end else begin
          ack = rx_dvld;
          if (rx_dvld && rx_eof) begin
            state_d   = IDLE;
            ev_fl_eof = 1'b1;
          end
        end
      end
      RECOVER: begin
        if (rst_cnt == 4'd0 && !rx_overrun) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Byte count, source address latch and frame status
  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n) begin
      byte_cnt  <= 11'd0;
      trunc_q   <= 1'b0;
      srcip_q   <= 32'd0;
      srcport_q <= 16'd0;
      frm_done  <= 1'b0;
      frm_len   <= 11'd0;
      frm_err   <= 2'b00;
    end else begin
      frm_done <= 1'b0;
      if (ev_start) begin
        byte_cnt  <= 11'd0;
        srcip_q   <= rx_srcip;
        srcport_q <= rx_srcport;
      end else if (accept) begin
        byte_cnt <= byte_cnt + 11'd1;
      end
      if (ev_trunc)                trunc_q <= 1'b1;
      else if (state_q != FLUSH)   trunc_q <= 1'b0;
      if (ev_eof) begin
        frm_done <= 1'b1;
        frm_len  <= byte_cnt + 11'd1;
        frm_err  <= rx_badframe ? 2'b10 : 2'b00;
      end else if (ev_fl_eof && trunc_q) begin
        frm_done <= 1'b1;
        frm_len  <= MAX_LEN;
        frm_err  <= 2'b01;
      end else if (ev_abort) begin
        frm_done <= 1'b1;
        frm_len  <= byte_cnt;
        frm_err  <= 2'b11;
      end
    end
  end

  // Receive-path reset pulse, counted from RECOVER entry
  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n) begin
      rx_rst  <= 1'b0;
      rst_cnt <= 4'd0;
    end else if (ev_rec) begin
      rx_rst  <= 1'b1;
      rst_cnt <= RST_LOAD;
    end else if (state_q == RECOVER) begin
      if (rst_cnt != 4'd0) rst_cnt <= rst_cnt - 4'd1;
      else                 rx_rst  <= 1'b0;
    end
  end

  // Saturating statistics, clear wins over increment
  always_ff @(posedge app_clk or negedge app_rst_n) begin
    if (!app_rst_n) begin
      frame_cnt <= 32'd0;
      drop_cnt  <= 16'd0;
      ovr_cnt   <= 16'd0;
    end else if (cnt_clr) begin
      frame_cnt <= 32'd0;
      drop_cnt  <= 16'd0;
      ovr_cnt   <= 16'd0;
    end else begin
      if (frm_end && frame_cnt != '1) frame_cnt <= frame_cnt + 32'd1;
      if (ev_drop && drop_cnt != '1)  drop_cnt  <= drop_cnt + 16'd1;
      if (ev_rec && ovr_cnt != '1)    ovr_cnt   <= ovr_cnt + 16'd1;
    end
  end

endmodule
